// File: rtl/data_memory_bytelane.sv
// RV32 data memory with per-byte store lanes, sign/zero-extended sub-word loads and fault flags.
// A power-on sweep writes a known pattern into every word before accesses are honoured.
module data_memory_bytelane #(
  parameter int unsigned DEPTH     = 256,
  parameter int unsigned INIT_MODE = 1
) (
  input  logic        CLK,
  input  logic        RST_DM_N,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [2:0]  Funct3,
  input  logic [31:0] A,
  input  logic [31:0] WD,
  output logic [31:0] RD,
  output logic        Ready,
  output logic        Misaligned,
  output logic        OutOfRange,
  output logic        BadFunct
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  typedef enum logic {StInit, StRun} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   init_idx_q, init_idx_d;
  logic [31:0]        mem [DEPTH];

  logic [31:0]        init_word;
  logic [IDX_W-1:0]   word_idx;
  logic [1:0]         byte_off;
  logic               active;
  logic               bad_funct, misaligned, out_of_range, fault;
  logic [31:0]        rd_word;
  logic [7:0]         sel_byte;
  logic [15:0]        sel_half;
  logic               store_en;
  logic [3:0]         lane_en;
  logic [31:0]        lane_data;

  // Sequencer: one word per edge during INIT, then RUN until the next reset.
  always_ff @(posedge CLK or negedge RST_DM_N) begin
    if (!RST_DM_N) begin
      state_q    <= StInit;
      init_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      init_idx_q <= init_idx_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    init_idx_d = init_idx_q;
    unique case (state_q)
      StInit: begin
        init_idx_d = init_idx_q + 1'b1;
        if (init_idx_q == IDX_W'(DEPTH - 1)) state_d = StRun;
      end
      StRun: begin
        state_d = StRun;
      end
      default: state_d = StInit;
    endcase
  end

  assign Ready = (state_q == StRun);

  always_comb begin
    init_word = '0;
    case (INIT_MODE)
      0:       init_word = '0;
      2:       init_word = ~32'(init_idx_q);
      default: init_word = 32'(init_idx_q);
    endcase
  end

  // Access decode
  assign word_idx = A[IDX_W+1:2];
  assign byte_off = A[1:0];
  assign active   = Ready & (MemRead | MemWrite);

  always_comb begin
    if (MemWrite) bad_funct = (Funct3 > 3'd2);
    else          bad_funct = (Funct3 == 3'b011) || (Funct3 == 3'b110) || (Funct3 == 3'b111);
  end

  assign misaligned   = ((Funct3[1:0] == 2'b01) & A[0]) | ((Funct3[1:0] == 2'b10) & (|A[1:0]));
  assign out_of_range = |A[31:IDX_W+2];

  assign BadFunct   = active & bad_funct;
  assign Misaligned = active & misaligned;
  assign OutOfRange = active & out_of_range;
  assign fault      = BadFunct | Misaligned | OutOfRange;

  // Loads: store-format funct3 values coincide with LB/LH/LW, so one decoder serves both.
  assign rd_word  = mem[word_idx];
  assign sel_byte = rd_word[8*byte_off +: 8];
  assign sel_half = A[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    RD = '0;
    if (Ready && !fault) begin
      case (Funct3)
        3'b000:  RD = {{24{sel_byte[7]}}, sel_byte};
        3'b100:  RD = {24'b0, sel_byte};
        3'b001:  RD = {{16{sel_half[15]}}, sel_half};
        3'b101:  RD = {16'b0, sel_half};
        3'b010:  RD = rd_word;
        default: RD = '0;
      endcase
    end
  end

  // Stores
  assign store_en = Ready & MemWrite & ~fault;

  always_comb begin
    lane_en   = 4'b0000;
    lane_data = WD;
    case (Funct3[1:0])
      2'b00: begin
        lane_en   = 4'b0001 << byte_off;
        lane_data = {4{WD[7:0]}};
      end
      2'b01: begin
        lane_en   = A[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{WD[15:0]}};
      end
      2'b10: begin
        lane_en   = 4'b1111;
        lane_data = WD;
      end
      default: lane_en = 4'b0000;
    endcase
  end

  // Contents are deliberately not reset; the INIT sweep rewrites every word.
  always_ff @(posedge CLK) begin
    if (state_q == StInit) begin
      mem[init_idx_q] <= init_word;
    end else if (store_en) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_en[i]) mem[word_idx][8*i +: 8] <= lane_data[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_memory_bytelane.sv
// Bench for data_memory_bytelane: init timing, directed lane/fault cases and random ops
// compared against a byte-level array model.
module tb_data_memory_bytelane;

  logic        CLK = 1'b0;
  logic        RST_DM_N;
  logic        MemWrite, MemRead;
  logic [2:0]  Funct3;
  logic [31:0] A, WD, RD;
  logic        Ready, Misaligned, OutOfRange, BadFunct;

  int total = 0;
  int bad   = 0;
  logic [31:0] model [256];

  always #5 CLK = ~CLK;

  data_memory_bytelane #(
    .DEPTH     (256),
    .INIT_MODE (1)
  ) dut (
    .CLK        (CLK),
    .RST_DM_N   (RST_DM_N),
    .MemWrite   (MemWrite),
    .MemRead    (MemRead),
    .Funct3     (Funct3),
    .A          (A),
    .WD         (WD),
    .RD         (RD),
    .Ready      (Ready),
    .Misaligned (Misaligned),
    .OutOfRange (OutOfRange),
    .BadFunct   (BadFunct)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic idle();
    MemWrite = 1'b0;
    MemRead  = 1'b0;
    Funct3   = 3'b000;
    A        = 32'h0;
    WD       = 32'h0;
  endtask

  // Counts edges from release until Ready; optionally re-asserts reset after edge rst_at.
  // A store is attempted at INIT edge 50 and must be ignored.
  task automatic sweep(input int rst_at, output int edges_seen);
    int e;
    bit got;
    e   = 0;
    got = 1'b0;
    for (int i = 0; i < 700 && !got; i++) begin
      @(negedge CLK);
      if (e == 50) begin
        MemWrite = 1'b1;
        MemRead  = 1'b1;
        Funct3   = 3'b010;
        A        = 32'h50;
        WD       = 32'hFFFF_FFFF;
        #1;
        check("init_store_rd", RD, 32'h0);
        check("init_store_flags", {Misaligned, OutOfRange, BadFunct}, 3'b000);
      end else begin
        idle();
      end
      if (e == rst_at) begin
        RST_DM_N = 1'b0;
        #1;
        check("midreset_ready", Ready, 1'b0);
        @(negedge CLK);
        RST_DM_N = 1'b1;
        e        = 0;
        rst_at   = -1;
      end
      @(posedge CLK);
      #1;
      e++;
      if (Ready) got = 1'b1;
    end
    edges_seen = got ? e : -1;
  endtask

  // One access: drive, evaluate against the model, then apply the store to the model.
  task automatic op(input string tag, input bit rd, input bit wr, input logic [2:0] f,
                    input logic [31:0] a, input logic [31:0] wd, output logic [31:0] obs);
    logic [31:0] w, v;
    bit mis, oor, bf;
    int nbytes, off;
    @(negedge CLK);
    MemRead  = rd;
    MemWrite = wr;
    Funct3   = f;
    A        = a;
    WD       = wd;
    #1;
    nbytes = 1 << f[1:0];
    off    = int'(a % 4);
    bf     = wr ? (f > 3'd2) : (f == 3'd3 || f == 3'd6 || f == 3'd7);
    mis    = (f[1:0] == 2'd1 && (a % 2) != 0) || (f[1:0] == 2'd2 && off != 0);
    oor    = (a >> 2) >= 256;
    v      = 32'h0;
    if (!(bf || mis || oor)) begin
      w = model[a >> 2];
      v = w >> (8 * off);
      case (f)
        3'd0:    v = {{24{v[7]}}, v[7:0]};
        3'd4:    v = {24'h0, v[7:0]};
        3'd1:    v = {{16{v[15]}}, v[15:0]};
        3'd5:    v = {16'h0, v[15:0]};
        3'd2:    v = w;
        default: v = 32'h0;
      endcase
    end
    check({tag, "/rd"}, RD, v);
    check({tag, "/mis"}, Misaligned, mis);
    check({tag, "/oor"}, OutOfRange, oor);
    check({tag, "/badf"}, BadFunct, bf);
    obs = RD;
    if (wr && !(bf || mis || oor)) begin
      w = model[a >> 2];
      for (int b = 0; b < nbytes; b++) w[8*(off+b) +: 8] = wd[8*b +: 8];
      model[a >> 2] = w;
    end
  endtask

  initial begin
    int n;
    logic [31:0] obs;
    int unsigned k;
    logic [31:0] ra;

    idle();
    RST_DM_N = 1'b0;
    repeat (3) @(negedge CLK);
    MemRead = 1'b1;
    Funct3  = 3'b010;
    A       = 32'h402;
    #1;
    check("rst_ready", Ready, 1'b0);
    check("rst_rd", RD, 32'h0);
    check("rst_flags", {Misaligned, OutOfRange, BadFunct}, 3'b000);
    idle();
    @(negedge CLK);
    RST_DM_N = 1'b1;

    sweep(100, n);
    check("ready_edges_after_midreset", n, 256);
    for (int i = 0; i < 256; i++) model[i] = 32'(i);

    op("lw_3fc", 1, 0, 3'b010, 32'h3FC, 0, obs);
    check("lw_3fc_const", obs, 32'h0000_00FF);
    op("lw_010", 1, 0, 3'b010, 32'h010, 0, obs);
    check("lw_010_const", obs, 32'h0000_0004);
    op("lw_050", 1, 0, 3'b010, 32'h050, 0, obs);
    check("init_store_ignored", obs, 32'h0000_0014);

    op("sw_20", 0, 1, 3'b010, 32'h20, 32'h1122_3344, obs);
    op("sb_22", 0, 1, 3'b000, 32'h22, 32'h0000_00A5, obs);
    op("lw_20", 1, 0, 3'b010, 32'h20, 0, obs);
    check("lane_word", obs, 32'h11A5_3344);
    op("lb_22", 1, 0, 3'b000, 32'h22, 0, obs);
    check("lb_sign", obs, 32'hFFFF_FFA5);
    op("lbu_22", 1, 0, 3'b100, 32'h22, 0, obs);
    check("lbu_zero", obs, 32'h0000_00A5);

    op("sh_42", 0, 1, 3'b001, 32'h42, 32'h0000_F00D, obs);
    op("lh_42", 1, 0, 3'b001, 32'h42, 0, obs);
    check("lh_sign", obs, 32'hFFFF_F00D);
    op("lhu_42", 1, 0, 3'b101, 32'h42, 0, obs);
    check("lhu_zero", obs, 32'h0000_F00D);
    op("lw_40", 1, 0, 3'b010, 32'h40, 0, obs);
    check("half_word", obs, 32'hF00D_0010);

    op("sw_mis", 0, 1, 3'b010, 32'h21, 32'hCAFE_BABE, obs);
    check("sw_mis_flag", Misaligned, 1'b1);
    op("sw_badf", 0, 1, 3'b011, 32'h20, 32'h0BAD_0BAD, obs);
    check("sw_badf_flag", BadFunct, 1'b1);
    op("lw_20_after", 1, 0, 3'b010, 32'h20, 0, obs);
    check("faults_no_write", obs, 32'h11A5_3344);
    op("lw_oor", 1, 0, 3'b010, 32'h400, 0, obs);
    check("oor_rd_zero", obs, 32'h0);

    @(negedge CLK);
    idle();
    A = 32'h0000_0403;
    Funct3 = 3'b111;
    #1;
    check("idle_flags", {Misaligned, OutOfRange, BadFunct}, 3'b000);

    op("rw_80", 1, 1, 3'b010, 32'h80, 32'hDEAD_BEEF, obs);
    check("rw_old", obs, 32'h0000_0020);
    op("lw_80", 1, 0, 3'b010, 32'h80, 0, obs);
    check("rw_new", obs, 32'hDEAD_BEEF);

    for (int i = 0; i < 300; i++) begin
      k  = $urandom_range(1, 3);
      ra = ($urandom_range(0, 15) == 0) ? 32'($urandom) : 32'($urandom_range(0, 1100));
      op("rand", k[0], k[1], 3'($urandom_range(0, 7)), ra, 32'($urandom), obs);
    end

    for (int i = 0; i < 256; i += 17) begin
      op("final_lw", 1, 0, 3'b010, 32'(i * 4), 0, obs);
    end

    idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_memory_bytelane.md
# data_memory_bytelane

Parametrised RV32 data memory with per-byte store lanes, sign/zero-extended sub-word loads and fault detection, placed on the processor's MEM stage and replacing the fixed 256-word, word-only data memory. After reset, an internal initialisation sequencer writes a known pattern into every word, one word per cycle. `Ready` stays low until the sweep completes. The core must stall on `!Ready`.

## Interface
- `DEPTH`, 256: number of 32-bit words; a power of two, 4..65536. `IDX_W = log2(DEPTH)`.
- `INIT_MODE`, 1: 0 = fill with zero; 1 = word `i` holds value `i`; 2 = word `i` holds `~i`.

- `CLK`  in  1  rising-edge clock
- `RST_DM_N`  in  1  asynchronous, active-low reset
- `MemWrite`  in  1  store request this cycle
- `MemRead`  in  1  load request this cycle; informational, because reads are always combinational
- `Funct3`  in  3  RV32 load/store funct3
- `A`  in  32  byte address
- `WD`  in  32  store data; the low bytes are used for SB/SH
- `RD`  out  32  load data, extended per `Funct3`
- `Ready`  out  1  initialisation done; accesses honoured
- `Misaligned`  out  1  the current access violates natural alignment
- `OutOfRange`  out  1  `A[31:2] >= DEPTH`
- `BadFunct`  out  1  `Funct3` is not a legal load/store encoding for the requested operation

## Operation
- State machine, two states:
  - INIT: entered on reset. Counter `init_idx` runs 0..`DEPTH-1`. Each cycle writes the pattern for `init_idx` into that word. After writing `DEPTH-1`, go to RUN.
  - RUN: normal accesses; no exit except reset.
- Word index is `A[IDX_W+1:2]`; byte offset is `A[1:0]`.
- Stores (`MemWrite=1`, RUN, no fault) write on the rising edge:
  - `000` SB: writes lane `A[1:0]` with `WD[7:0]`.
  - `001` SH: writes lanes {`A[1]`*2, +1} with `WD[15:0]`.
  - `010` SW: writes all four lanes with `WD`.
  - Lanes not selected are unchanged.
- Loads, combinational from the word at the current index:
  - `000` LB: sign-extends the selected byte.
  - `100` LBU: zero-extends the selected byte.
  - `001` LH: sign-extends the selected halfword.
  - `101` LHU: zero-extends the selected halfword.
  - `010` LW: returns the whole word.
- Fault detection:
  - `Misaligned`: H-type with `A[0]=1`, or W-type with `A[1:0]!=0`.
  - `BadFunct`:
    - store with `Funct3` not in {000, 001, 010};
    - load with `Funct3` in {011, 110, 111}.
- Flags are valid only when `Ready & (MemRead|MemWrite)`; otherwise they are 0.
- Any flag set:
  - the store is suppressed, so memory is unchanged;
  - `RD = 0`.
- If `MemRead` and `MemWrite` are both 1, store semantics apply for the write. `RD` uses store-format decoding: SB→LB, SH→LH, SW→LW.
- When `!Ready`:
  - `RD = 0`;
  - all requests are ignored;
  - flags are 0.

## Timing
- Reset asserted (asynchronous):
  - state = INIT, `init_idx = 0`;
  - `Ready = 0`, `RD = 0`, all flags 0.
  - Memory contents are not cleared asynchronously; the INIT sweep rewrites them.
- Initialisation timing:
  - The first INIT write happens at the first rising edge after `RST_DM_N` deasserts.
  - `Ready` (registered) rises after exactly `DEPTH` edges; for `DEPTH=256`, it is visible from edge 256.
- Reset mid-sweep or mid-RUN restarts INIT from index 0. Any store in flight is lost.
- Store latency is one edge.
- Read-during-write to the same word in the same cycle: `RD` shows the old data. The new data is visible after the edge.
- Loads have zero latency: `RD` follows `A`/`Funct3` combinationally in RUN.
- Address wrap: none. Indices at or above `DEPTH` raise `OutOfRange` and never alias.

## Test plan
- Reset, then release:
  - `Ready=0` for 256 edges, then `Ready=1`.
  - With `INIT_MODE=1`: LW at `A=0x3FC` gives `RD=0x000000FF`; LW at `A=0x010` gives `0x00000004`.
- Byte lanes:
  - SW `0x11223344` @`0x20`, then SB `WD=0xA5` @`0x22`.
  - LW @`0x20` gives `0x11A53344`.
  - LB @`0x22` gives `0xFFFFFFA5`; LBU @`0x22` gives `0x000000A5`.
- Halfwords:
  - SH `WD=0x0000F00D` @`0x42`.
  - LH @`0x42` gives `0xFFFFF00D`; LHU gives `0x0000F00D`; LW @`0x40` gives `0xF00D0010`.
- Faults:
  - SW @`0x21` gives `Misaligned=1`; memory is unchanged.
  - LW @`0x400` gives `OutOfRange=1`, `RD=0`.
  - Store with `Funct3=011` gives `BadFunct=1`; no write.
- Reset at INIT edge 100:
  - `Ready` stays low and rises 256 edges after the second release.
  - A store issued at edge 50 of INIT has no effect: word 0x14 reads `0x00000014`.
- Same-cycle read and write:
  - SW `0xDEADBEEF` @`0x80` with `MemRead=1`: `RD` shows `0x00000020` in that cycle and `0xDEADBEEF` the next cycle.
